// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and feedback for the 8-bit LFSR pattern link.
// The generator and checker both use lfsr_next so that their feedback is identical.
package lfsr_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1
    } lfsr_chk_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s,
        input logic [LFSR_W-1:0] taps
    );
        return {s[LFSR_W-2:0], ^(s & taps)};
    endfunction

endpackage

// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: receive-side checker for the 8-bit LFSR pattern link.
// It seeds from incoming data in HUNT, then free-runs its own LFSR and counts mismatches in LOCKED.
//   clock     : rising-edge clock
//   r         : async active-low reset
//   d, valid  : received LFSR word and its qualifier
//   clear_err : sync clear of err_count (wins over a same-cycle increment)
//   locked    : high while in LOCKED
//   err_pulse : one-cycle pulse per mismatching word while LOCKED
//   err_count : saturating mismatch count
//   state     : current FSM state
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] TAPS     = LFSR_TAPS,
    parameter int                LOCK_CNT = 4,
    parameter int                LOSS_CNT = 3,
    parameter int                ERR_W    = 16
) (
    input  logic              clock,
    input  logic              r,
    input  logic [LFSR_W-1:0] d,
    input  logic              valid,
    input  logic              clear_err,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [1:0]        state
);

    lfsr_chk_state_t   state_q, state_d;
    logic [LFSR_W-1:0] exp_q, exp_d;
    logic [2:0]        run_q, run_d;
    logic [2:0]        miss_q, miss_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              pulse_q, pulse_d;

    logic [2:0] run_inc;
    logic [2:0] miss_inc;

    assign run_inc  = run_q + 3'd1;
    assign miss_inc = miss_q + 3'd1;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        run_d   = run_q;
        miss_d  = miss_q;
        err_d   = err_q;
        pulse_d = 1'b0;

        case (state_q)
            HUNT: begin
                if (valid) begin
                    if (d == '0) begin
                        // All-zero is the LFSR lockup state: never a legal seed.
                        run_d = 3'd0;
                    end else if (run_q == 3'd0 || d != exp_q) begin
                        exp_d = lfsr_next(d, TAPS);
                        run_d = 3'd1;
                    end else begin
                        exp_d = lfsr_next(d, TAPS);
                        if (run_inc == 3'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            run_d   = 3'd0;
                            miss_d  = 3'd0;
                        end else begin
                            run_d = run_inc;
                        end
                    end
                end
            end
            LOCKED: begin
                if (valid) begin
                    // Flywheel: once locked, never reseed from received data.
                    exp_d = lfsr_next(exp_q, TAPS);
                    if (d != exp_q) begin
                        pulse_d = 1'b1;
                        miss_d  = miss_inc;
                        if (!(&err_q)) begin
                            err_d = err_q + {{(ERR_W-1){1'b0}}, 1'b1};
                        end
                        if (miss_inc == 3'(LOSS_CNT)) begin
                            state_d = HUNT;
                            run_d   = 3'd0;
                        end
                    end else begin
                        miss_d = 3'd0;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        if (clear_err) begin
            err_d = '0;
        end
    end

    always_ff @(posedge clock or negedge r) begin
        if (!r) begin
            state_q <= HUNT;
            exp_q   <= '0;
            run_q   <= 3'd0;
            miss_q  <= 3'd0;
            err_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            run_q   <= run_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            pulse_q <= pulse_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = pulse_q;
    assign err_count = err_q;
    assign state     = state_q;

endmodule

// File: doc/lfsr_seq_checker.md
Name: lfsr_seq_checker

Overview:
Receiver/checker end of the team's 8-bit LFSR pattern link. It consumes one parallel 8-bit LFSR state per valid cycle from the pattern generator. It self-synchronises by seeding from the incoming data, then free-runs its own LFSR to flag and count mismatching words. Used on the receive side of register/flip-flop chain tests to prove data integrity.

Parameters:
TAPS, 8'hB8, feedback mask for x^8+x^6+x^5+x^4+1 (maximal length, period 255)
LOCK_CNT, 4, consecutive good words (seed included) required to enter LOCKED; legal range 2..7
LOSS_CNT, 3, consecutive bad words in LOCKED that force a return to HUNT; legal range 1..7
ERR_W, 16, width of the saturating error counter

Ports:
clock  input  1  single rising-edge clock
r  input  1  reset, asynchronous, active-low
d  input  8  received LFSR word
valid  input  1  d is valid this cycle
clear_err  input  1  synchronous clear of err_count
locked  output  1  high while state==LOCKED
err_pulse  output  1  one-cycle pulse per mismatching word while LOCKED
err_count  output  ERR_W  saturating mismatch count
state  output  2  current FSM state (debug)

Behaviour:
- Next-state function: next(s) = {s[6:0], ^(s & TAPS)}. Example chain: 01,02,04,08,11,23,47.
- Internal registers: exp[7:0], run_cnt[2:0], miss_cnt[2:0], state, err_count, err_pulse. All outputs are registered and reflect a valid word one clock edge after it is sampled.
- Reset (r low): takes effect immediately, regardless of clock. Values: state=HUNT, exp=0, run_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_count=0. Reset mid-operation drops lock at once.
- States: HUNT=2'd0, LOCKED=2'd1. Encodings 2 and 3 are unused and recover to HUNT on the next edge.
- valid=0: all registers hold, err_pulse=0.
- HUNT, on a valid word:
  - d==0 (illegal LFSR state): run_cnt<=0, no seed.
  - else if run_cnt==0: seed. exp<=next(d), run_cnt<=1.
  - else if d==exp: exp<=next(d), run_cnt<=run_cnt+1. If run_cnt+1==LOCK_CNT then state<=LOCKED, run_cnt<=0, miss_cnt<=0.
  - else (nonzero mismatch): reseed. exp<=next(d), run_cnt<=1.
- HUNT never counts errors and never raises err_pulse.
- LOCKED, on a valid word:
  - exp<=next(exp) always (flywheel; never reseeds from received data).
  - d!=exp: err_pulse<=1, err_count<=err_count+1 (saturates at all-ones), miss_cnt<=miss_cnt+1. If miss_cnt+1==LOSS_CNT then state<=HUNT, run_cnt<=0.
  - d==exp: miss_cnt<=0, err_pulse<=0.
- clear_err: sets err_count<=0 and overrides any same-cycle increment. Does not affect state or err_pulse.
- Latency: the LOCK_CNT-th good word sets locked=1 on the same edge that samples it. Loss of lock occurs on the edge that samples the LOSS_CNT-th consecutive bad word; that word is still counted and pulsed.

Decomposition:
- Package lfsr_pkg holds:
  - typedef enum logic[1:0] {HUNT, LOCKED} lfsr_chk_state_t
  - localparam LFSR_W=8 and default TAPS
  - function lfsr_next(s, taps), shared with the generator so both ends use identical feedback.
- No sub-module; a single always_ff plus combinational next-state logic.

Test Plan:
1. Release r, feed valid words 01,02,04,08 back-to-back -> locked=1 after the 08 edge, err_count=0, state=1.
2. Locked after 01..08, feed 11, then 55 (expected 23), then 47 -> single err_pulse on the 55 edge, err_count=1, locked stays 1, no error on 47 (flywheel).
3. Locked, feed three consecutive wrong words (00,00,00) -> err_count=3, locked falls on the third edge, state=0; then 01,02,04,08 relocks.
4. In HUNT, feed 00,01,02,FF,04,08 -> no lock (zero ignored, FF forces reseed and 04 mismatches next(FF)); no err_pulse, err_count=0. Valid gaps (valid=0) between good words 01,_,02,_,04,_,08 -> locks normally.
5. ERR_W=2: 5 errors while LOCKED with LOSS_CNT=7 -> err_count saturates at 3. Assert clear_err on the same cycle as an error -> err_count=0.
6. Locked with err_count=2; drive r low between clock edges -> locked=0, err_count=0, err_pulse=0 immediately, before the next clock edge.
